// File: rtl/branch_predictor_unit.sv
// Fetch-stage gshare direction predictor with a direct-mapped branch target buffer.
// Lookup is purely combinational from registered state. Training happens once per
// resolved, unstalled branch in decode. History is non-speculative.
module branch_predictor_unit #(
    parameter int unsigned PC_W  = 10,
    parameter int unsigned IDX_W = 6,
    parameter int unsigned GHR_W = 6,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    // Fetch side
    input  logic [PC_W-1:0]  pcF,
    output logic             predictionF,
    output logic [PC_W-1:0]  predTargetF,
    output logic             btbHitF,
    output logic [IDX_W-1:0] indexF,
    // Decode side
    input  logic [PC_W-1:0]  pcD,
    input  logic [IDX_W-1:0] indexD,
    input  logic             branchD,
    input  logic             takenBranchD,
    input  logic [PC_W-1:0]  targetD,
    input  logic             predictionD,
    input  logic             stallD,
    // Performance counters
    output logic [CNT_W-1:0] branchCount,
    output logic [CNT_W-1:0] mispredCount
);

    localparam int unsigned Entries = 2 ** IDX_W;
    localparam int unsigned TagW    = PC_W - IDX_W;

    // Prediction state
    logic [1:0]       r_cnt    [Entries];
    logic             r_valid  [Entries];
    logic [TagW-1:0]  r_tag    [Entries];
    logic [PC_W-1:0]  r_target [Entries];
    logic [GHR_W-1:0] r_ghr;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    logic [IDX_W-1:0] w_ghr_ext;
    logic [IDX_W-1:0] w_btb_idx_f;
    logic [TagW-1:0]  w_tag_f;
    logic [IDX_W-1:0] w_btb_idx_d;
    logic [TagW-1:0]  w_tag_d;
    logic             w_upd;
    logic             w_mispred;

    // History is zero-extended so GHR_W may be narrower than the index.
    assign w_ghr_ext   = IDX_W'(r_ghr);
    assign w_btb_idx_f = pcF[IDX_W-1:0];
    assign w_tag_f     = pcF[PC_W-1:IDX_W];
    assign w_btb_idx_d = pcD[IDX_W-1:0];
    assign w_tag_d     = pcD[PC_W-1:IDX_W];

    // A stalled branch trains only on its final unstalled cycle; reset drops the update.
    assign w_upd     = branchD && !stallD && !reset;
    assign w_mispred = takenBranchD ^ predictionD;

    // Fetch lookup: gshare index for direction, PC index for the BTB
    always_comb begin
        indexF      = w_btb_idx_f ^ w_ghr_ext;
        btbHitF     = r_valid[w_btb_idx_f] && (r_tag[w_btb_idx_f] == w_tag_f);
        predictionF = btbHitF && r_cnt[indexF][1];
        predTargetF = r_target[w_btb_idx_f];
    end

    assign branchCount  = r_branch_cnt;
    assign mispredCount = r_mispred_cnt;

    // Resettable state: direction counters, BTB valid bits, history and perf counters
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < Entries; i++) begin
                r_cnt[i]   <= 2'b01;
                r_valid[i] <= 1'b0;
            end
            r_ghr         <= '0;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (w_upd) begin
            if (takenBranchD) begin
                if (r_cnt[indexD] != 2'b11) begin
                    r_cnt[indexD] <= r_cnt[indexD] + 2'b01;
                end
                r_valid[w_btb_idx_d] <= 1'b1;
            end else begin
                if (r_cnt[indexD] != 2'b00) begin
                    r_cnt[indexD] <= r_cnt[indexD] - 2'b01;
                end
            end
            r_ghr <= {r_ghr[GHR_W-2:0], takenBranchD};
            if (r_branch_cnt != '1) begin
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            end
            if (w_mispred && (r_mispred_cnt != '1)) begin
                r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
            end
        end
    end

    // BTB tag/target payload: only meaningful behind a valid bit, so never reset
    always_ff @(posedge clk) begin
        if (w_upd && takenBranchD) begin
            r_tag[w_btb_idx_d]    <= w_tag_d;
            r_target[w_btb_idx_d] <= targetD;
        end
    end

endmodule

// File: tb/tb_branch_predictor_unit.sv
// Directed self-checking bench for branch_predictor_unit; expected values are hand-computed.
module tb_branch_predictor_unit;

    localparam int unsigned PC_W  = 10;
    localparam int unsigned IDX_W = 6;
    localparam int unsigned GHR_W = 6;
    localparam int unsigned CNT_W = 16;

    logic             clk;
    logic             reset;
    logic [PC_W-1:0]  pcF;
    logic             predictionF;
    logic [PC_W-1:0]  predTargetF;
    logic             btbHitF;
    logic [IDX_W-1:0] indexF;
    logic [PC_W-1:0]  pcD;
    logic [IDX_W-1:0] indexD;
    logic             branchD;
    logic             takenBranchD;
    logic [PC_W-1:0]  targetD;
    logic             predictionD;
    logic             stallD;
    logic [CNT_W-1:0] branchCount;
    logic [CNT_W-1:0] mispredCount;

    int n_checks = 0;
    int n_errors = 0;

    branch_predictor_unit #(
        .PC_W  (PC_W),
        .IDX_W (IDX_W),
        .GHR_W (GHR_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pcF          (pcF),
        .predictionF  (predictionF),
        .predTargetF  (predTargetF),
        .btbHitF      (btbHitF),
        .indexF       (indexF),
        .pcD          (pcD),
        .indexD       (indexD),
        .branchD      (branchD),
        .takenBranchD (takenBranchD),
        .targetD      (targetD),
        .predictionD  (predictionD),
        .stallD       (stallD),
        .branchCount  (branchCount),
        .mispredCount (mispredCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One unstalled update cycle; inputs change #1 after the edge
    task automatic upd(input logic [PC_W-1:0] pc, input logic [IDX_W-1:0] idx, input logic tk,
                       input logic [PC_W-1:0] tgt, input logic pd);
        pcD          = pc;
        indexD       = idx;
        takenBranchD = tk;
        targetD      = tgt;
        predictionD  = pd;
        stallD       = 1'b0;
        branchD      = 1'b1;
        @(posedge clk);
        #1;
        branchD = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset        = 1'b1;
        pcF          = 10'h004;
        pcD          = '0;
        indexD       = '0;
        branchD      = 1'b0;
        takenBranchD = 1'b0;
        targetD      = '0;
        predictionD  = 1'b0;
        stallD       = 1'b0;
        idle(2);
        reset = 1'b0;
        #1;

        // Reset state
        check_eq("rst_pred",   32'(predictionF),  32'd0);
        check_eq("rst_hit",    32'(btbHitF),      32'd0);
        check_eq("rst_index",  32'(indexF),       32'h04);
        check_eq("rst_bcnt",   32'(branchCount),  32'd0);
        check_eq("rst_mcnt",   32'(mispredCount), 32'd0);

        // Two taken updates, mispredicted: ghr 0 -> 1 -> 3
        upd(10'h004, 6'h04, 1'b1, 10'h020, 1'b0);
        check_eq("a_index",  32'(indexF),      32'h05);
        check_eq("a_hit",    32'(btbHitF),     32'd1);
        check_eq("a_target", 32'(predTargetF), 32'h020);
        check_eq("a_pred",   32'(predictionF), 32'd0);
        upd(10'h004, 6'h05, 1'b1, 10'h020, 1'b0);
        check_eq("b_index",  32'(indexF),       32'h07);
        check_eq("b_hit",    32'(btbHitF),      32'd1);
        check_eq("b_target", 32'(predTargetF),  32'h020);
        check_eq("b_pred",   32'(predictionF),  32'd0);
        check_eq("b_mcnt",   32'(mispredCount), 32'd2);
        check_eq("b_bcnt",   32'(branchCount),  32'd2);
        // Same BTB slot, different tag
        pcF = 10'h044;
        #1;
        check_eq("tag_miss_hit",  32'(btbHitF),     32'd0);
        check_eq("tag_miss_pred", 32'(predictionF), 32'd0);
        pcF = 10'h004;

        // Branch held by stall for 3 cycles, then released: trains once
        pcD          = 10'h004;
        indexD       = 6'h07;
        takenBranchD = 1'b1;
        targetD      = 10'h020;
        predictionD  = 1'b1;
        branchD      = 1'b1;
        stallD       = 1'b1;
        idle(3);
        check_eq("stall_bcnt",  32'(branchCount), 32'd2);
        check_eq("stall_index", 32'(indexF),      32'h07);
        stallD = 1'b0;
        idle(1);
        branchD = 1'b0;
        check_eq("rel_bcnt",  32'(branchCount),  32'd3);
        check_eq("rel_mcnt",  32'(mispredCount), 32'd2);
        check_eq("rel_index", 32'(indexF),       32'h03);
        check_eq("rel_pred",  32'(predictionF),  32'd0);

        // 5 taken to index 0x3B: saturates at 11; ghr ends at 0x3F
        for (int i = 0; i < 5; i++) upd(10'h004, 6'h3B, 1'b1, 10'h020, 1'b1);
        check_eq("sat_up_index", 32'(indexF),      32'h3B);
        check_eq("sat_up_pred",  32'(predictionF), 32'd1);
        check_eq("sat_up_bcnt",  32'(branchCount), 32'd8);

        // 5 not-taken to 0x3B: saturates at 00; ghr ends at 0x20
        for (int i = 0; i < 5; i++) upd(10'h004, 6'h3B, 1'b0, 10'h3FF, 1'b0);
        check_eq("sat_dn_index",  32'(indexF),      32'h24);
        check_eq("sat_dn_hit",    32'(btbHitF),     32'd1);
        check_eq("sat_dn_target", 32'(predTargetF), 32'h020);

        // 6 taken elsewhere to restore ghr=0x3F, then observe 0x3B (00, not wrapped)
        for (int i = 0; i < 6; i++) upd(10'h004, 6'h10, 1'b1, 10'h020, 1'b0);
        check_eq("sat_dn_pred", 32'(predictionF),  32'd0);
        check_eq("f_bcnt",      32'(branchCount),  32'd19);
        check_eq("f_mcnt",      32'(mispredCount), 32'd8);

        // Bring 0x3B to 01 (taken keeps ghr at 0x3F), then collide
        upd(10'h004, 6'h3B, 1'b1, 10'h020, 1'b0);
        check_eq("pre_col_pred", 32'(predictionF), 32'd0);
        pcD          = 10'h004;
        indexD       = 6'h3B;
        takenBranchD = 1'b1;
        targetD      = 10'h020;
        predictionD  = 1'b0;
        branchD      = 1'b1;
        #1;
        check_eq("col_old_index", 32'(indexF),      32'h3B);
        check_eq("col_old_pred",  32'(predictionF), 32'd0);
        @(posedge clk);
        #1;
        branchD = 1'b0;
        check_eq("col_new_pred", 32'(predictionF), 32'd1);

        // Idle with branchD=0: nothing moves
        idle(3);
        check_eq("idle_bcnt",  32'(branchCount),  32'd21);
        check_eq("idle_mcnt",  32'(mispredCount), 32'd10);
        check_eq("idle_index", 32'(indexF),       32'h3B);

        // Reset during an update cycle: update dropped, state cleared
        pcD          = 10'h004;
        indexD       = 6'h3B;
        takenBranchD = 1'b1;
        targetD      = 10'h020;
        predictionD  = 1'b0;
        branchD      = 1'b1;
        reset        = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        branchD = 1'b0;
        #1;
        check_eq("mrst_bcnt",  32'(branchCount),  32'd0);
        check_eq("mrst_mcnt",  32'(mispredCount), 32'd0);
        check_eq("mrst_hit",   32'(btbHitF),      32'd0);
        check_eq("mrst_pred",  32'(predictionF),  32'd0);
        check_eq("mrst_index", 32'(indexF),       32'h04);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
